// File: rtl/fixed_point_vec_mul_pkg.sv
// Shared definitions for the fixed-point vector multiplier and the accumulator
// stage: FSM state encoding and a ceiling-log2 helper for counter sizing.
package fixed_point_vec_mul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Smallest width able to index n entries; at least 1 bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/fixed_point_mul_sat.sv
// Registered signed fixed-point multiply: full product, arithmetic shift by
// FRAC_BITS (floor), saturate to WIDTH bits. One-cycle latency.
module fixed_point_mul_sat #(
    parameter int WIDTH     = 8,
    parameter int FRAC_BITS = 3
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic [WIDTH-1:0] VALUE_A_IN,
    input  logic [WIDTH-1:0] VALUE_B_IN,
    input  logic             VALID_IN,
    output logic [WIDTH-1:0] VALUE_OUT,
    output logic             VALID_OUT
);

    localparam int PW = 2 * WIDTH;
    localparam logic signed [PW-1:0] SAT_MAX = PW'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [PW-1:0] SAT_MIN = PW'(-(2 ** (WIDTH - 1)));

    logic signed [PW-1:0]    full_prod;
    logic signed [PW-1:0]    shifted;
    logic        [WIDTH-1:0] sat_d;
    logic        [WIDTH-1:0] value_q;
    logic                    valid_q;

    always_comb begin
        full_prod = $signed(VALUE_A_IN) * $signed(VALUE_B_IN);
        shifted   = full_prod >>> FRAC_BITS;
        if (shifted > SAT_MAX) begin
            sat_d = SAT_MAX[WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_d = SAT_MIN[WIDTH-1:0];
        end else begin
            sat_d = shifted[WIDTH-1:0];
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            value_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= VALID_IN;
            if (VALID_IN) begin
                value_q <= sat_d;
            end
        end
    end

    assign VALUE_OUT = value_q;
    assign VALID_OUT = valid_q;

endmodule

// File: rtl/fixed_point_vec_mul.sv
// Element-wise fixed-point vector multiplier feeding the neuron accumulator.
// One shared multiplier is time-multiplexed; all products publish together.
module fixed_point_vec_mul
    import fixed_point_vec_mul_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int FRAC_BITS   = 3,
    parameter int NUM_OUTPUTS = 16
) (
    input  logic                         CLK,
    input  logic                         RSTN,
    input  logic [NUM_OUTPUTS*WIDTH-1:0] VALUES_IN,
    input  logic [NUM_OUTPUTS*WIDTH-1:0] WEIGHTS_IN,
    input  logic                         VALID_IN,
    output logic                         BUSY_OUT,
    output logic [NUM_OUTPUTS*WIDTH-1:0] VALUES_OUT,
    output logic                         VALID_OUT
);

    localparam int CNT_W = clog2(NUM_OUTPUTS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_OUTPUTS - 1);

    state_t state_q, state_d;

    logic [NUM_OUTPUTS-1:0][WIDTH-1:0] val_q;
    logic [NUM_OUTPUTS-1:0][WIDTH-1:0] wgt_q;
    logic [NUM_OUTPUTS-1:0][WIDTH-1:0] work_q;
    logic [NUM_OUTPUTS-1:0][WIDTH-1:0] work_d;
    logic [NUM_OUTPUTS-1:0][WIDTH-1:0] out_q;

    logic [CNT_W-1:0] issue_cnt_q;
    logic [CNT_W-1:0] wr_cnt_q;
    logic [WIDTH-1:0] mul_a_q;
    logic [WIDTH-1:0] mul_b_q;
    logic             mul_en_q;
    logic             valid_out_q;

    logic [WIDTH-1:0] prod;
    logic             prod_vld;
    logic             start;
    logic             last_issue;
    logic             last_wr;

    assign start      = (state_q == IDLE) && VALID_IN;
    assign last_issue = (state_q == ISSUE) && (issue_cnt_q == LAST_IDX);
    assign last_wr    = prod_vld && (wr_cnt_q == LAST_IDX);

    fixed_point_mul_sat #(
        .WIDTH     (WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_mul (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .VALUE_A_IN (mul_a_q),
        .VALUE_B_IN (mul_b_q),
        .VALID_IN   (mul_en_q),
        .VALUE_OUT  (prod),
        .VALID_OUT  (prod_vld)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (VALID_IN)   state_d = ISSUE;
            ISSUE:   if (last_issue) state_d = DRAIN;
            DRAIN:   state_d = DRAIN;
            default: state_d = IDLE;
        endcase
        // The final product closes the operation regardless of state.
        if (last_wr) begin
            state_d = IDLE;
        end
    end

    // Working register with the incoming product merged, so the last product
    // lands in VALUES_OUT on the same edge it arrives.
    always_comb begin
        work_d = work_q;
        work_d[wr_cnt_q] = prod;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            val_q       <= '0;
            wgt_q       <= '0;
            work_q      <= '0;
            out_q       <= '0;
            issue_cnt_q <= '0;
            wr_cnt_q    <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_en_q    <= 1'b0;
            valid_out_q <= 1'b0;
        end else begin
            valid_out_q <= 1'b0;
            mul_en_q    <= 1'b0;

            if (start) begin
                val_q       <= VALUES_IN;
                wgt_q       <= WEIGHTS_IN;
                issue_cnt_q <= '0;
                wr_cnt_q    <= '0;
            end

            if (state_q == ISSUE) begin
                mul_a_q     <= val_q[issue_cnt_q];
                mul_b_q     <= wgt_q[issue_cnt_q];
                mul_en_q    <= 1'b1;
                issue_cnt_q <= issue_cnt_q + CNT_W'(1);
            end

            if (prod_vld) begin
                work_q   <= work_d;
                wr_cnt_q <= wr_cnt_q + CNT_W'(1);
                if (last_wr) begin
                    out_q       <= work_d;
                    valid_out_q <= 1'b1;
                    wr_cnt_q    <= '0;
                end
            end
        end
    end

    assign BUSY_OUT   = (state_q != IDLE);
    assign VALUES_OUT = out_q;
    assign VALID_OUT  = valid_out_q;

endmodule

// File: tb/tb_fixed_point_vec_mul.sv
// Self-checking bench for fixed_point_vec_mul (WIDTH=8, FRAC_BITS=3, NUM_OUTPUTS=4).
module tb_fixed_point_vec_mul;

    localparam int W = 8;
    localparam int F = 3;
    localparam int N = 4;

    typedef int vec_t [N];

    logic           CLK = 1'b0;
    logic           RSTN = 1'b0;
    logic [N*W-1:0] VALUES_IN = '0;
    logic [N*W-1:0] WEIGHTS_IN = '0;
    logic           VALID_IN = 1'b0;
    logic           BUSY_OUT;
    logic [N*W-1:0] VALUES_OUT;
    logic           VALID_OUT;

    int n_pass = 0;
    int n_total = 0;

    fixed_point_vec_mul #(.WIDTH(W), .FRAC_BITS(F), .NUM_OUTPUTS(N)) dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .VALUES_IN  (VALUES_IN),
        .WEIGHTS_IN (WEIGHTS_IN),
        .VALID_IN   (VALID_IN),
        .BUSY_OUT   (BUSY_OUT),
        .VALUES_OUT (VALUES_OUT),
        .VALID_OUT  (VALID_OUT)
    );

    always #5 CLK = ~CLK;

    // Real-valued product a*b/2^F, floored, then clamped to the signed range.
    function automatic int ref_mul(input int a, input int b);
        int p, d, q;
        p = a * b;
        d = 1 << F;
        q = (p >= 0) ? (p / d) : -((-p + d - 1) / d);
        if (q > (1 << (W - 1)) - 1) q = (1 << (W - 1)) - 1;
        if (q < -(1 << (W - 1)))    q = -(1 << (W - 1));
        return q;
    endfunction

    function automatic logic [N*W-1:0] pack(input vec_t v);
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'(v[i]);
        return r;
    endfunction

    function automatic logic [N*W-1:0] ref_vec(input vec_t v, input vec_t w);
        vec_t r;
        for (int i = 0; i < N; i++) r[i] = ref_mul(v[i], w[i]);
        return pack(r);
    endfunction

    task automatic rand_vec(output vec_t v);
        for (int i = 0; i < N; i++) v[i] = int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input vec_t v, input vec_t w);
        VALUES_IN  = pack(v);
        WEIGHTS_IN = pack(w);
    endtask

    // Pulse VALID_IN at edge 0, then watch edges 1..9 for the result.
    task automatic run_op(input vec_t v, input vec_t w, output logic [N*W-1:0] got,
                          output int edge_at, output int pulses);
        drive(v, w);
        VALID_IN = 1'b1;
        tick();
        VALID_IN = 1'b0;
        got = '0;
        edge_at = -1;
        pulses = 0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (VALID_OUT) begin
                pulses++;
                if (edge_at < 0) begin
                    edge_at = k;
                    got = VALUES_OUT;
                end
            end
        end
    endtask

    task automatic test_reset();
        RSTN = 1'b0;
        tick();
        tick();
        n_total++;
        if (VALUES_OUT !== '0 || VALID_OUT !== 1'b0 || BUSY_OUT !== 1'b0) begin
            $display("FAIL reset_state: values=%h valid=%b busy=%b, want 0/0/0", VALUES_OUT, VALID_OUT, BUSY_OUT);
        end else n_pass++;
        RSTN = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        vec_t v = '{16, -8, 1, -1};
        vec_t w = '{12, 4, 1, 1};
        logic [N*W-1:0] exp_v;
        exp_v = ref_vec(v, w);
        drive(v, w);
        VALID_IN = 1'b1;
        tick();
        VALID_IN = 1'b0;
        n_total++;
        if (BUSY_OUT !== 1'b1) $display("FAIL basic_busy_e0: busy=%b want 1", BUSY_OUT);
        else n_pass++;
        for (int k = 1; k <= 7; k++) begin
            tick();
            n_total++;
            if (VALID_OUT !== (k == 6)) $display("FAIL basic_valid_e%0d: valid=%b want %b", k, VALID_OUT, (k == 6));
            else n_pass++;
            n_total++;
            if (BUSY_OUT !== (k <= 5)) $display("FAIL basic_busy_e%0d: busy=%b want %b", k, BUSY_OUT, (k <= 5));
            else n_pass++;
            if (k >= 6) begin
                n_total++;
                if (VALUES_OUT !== exp_v || VALUES_OUT !== 32'hFF00FC18)
                    $display("FAIL basic_values_e%0d: got %h want %h", k, VALUES_OUT, exp_v);
                else n_pass++;
            end
        end
    endtask

    task automatic test_saturation();
        vec_t v = '{127, -128, 127, -128};
        vec_t w = '{16, 16, -128, -128};
        logic [N*W-1:0] got;
        int e, p;
        run_op(v, w, got, e, p);
        n_total++;
        if (p !== 1 || e !== 6) $display("FAIL sat_timing: pulses=%0d edge=%0d want 1/6", p, e);
        else n_pass++;
        n_total++;
        if (got !== ref_vec(v, w) || got !== 32'h7F80807F)
            $display("FAIL sat_values: got %h want %h", got, ref_vec(v, w));
        else n_pass++;
    endtask

    task automatic test_busy_ignore();
        vec_t va, wa, vb, wb;
        logic [N*W-1:0] got;
        int e, p;
        rand_vec(va); rand_vec(wa); rand_vec(vb); rand_vec(wb);
        drive(va, wa);
        VALID_IN = 1'b1;
        tick();
        VALID_IN = 1'b0;
        p = 0; e = -1; got = '0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 3) begin
                drive(vb, wb);
                VALID_IN = 1'b1;
            end
            tick();
            VALID_IN = 1'b0;
            if (VALID_OUT) begin
                p++;
                if (e < 0) begin
                    e = k;
                    got = VALUES_OUT;
                end
            end
        end
        n_total++;
        if (p !== 1 || e !== 6) $display("FAIL busy_ignore_pulses: pulses=%0d edge=%0d want 1/6", p, e);
        else n_pass++;
        n_total++;
        if (got !== ref_vec(va, wa)) $display("FAIL busy_ignore_values: got %h want %h", got, ref_vec(va, wa));
        else n_pass++;
    endtask

    task automatic test_snapshot();
        vec_t va = '{20, -33, 64, 5};
        vec_t wa = '{9, 17, -3, 100};
        vec_t vb = '{-1, 1, -1, 1};
        logic [N*W-1:0] got;
        int e;
        drive(va, wa);
        VALID_IN = 1'b1;
        tick();
        VALID_IN = 1'b0;
        VALUES_IN = pack(vb);
        e = -1; got = '0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (VALID_OUT && e < 0) begin
                e = k;
                got = VALUES_OUT;
            end
        end
        n_total++;
        if (e !== 6 || got !== ref_vec(va, wa))
            $display("FAIL snapshot: edge=%0d got %h want edge 6 value %h", e, got, ref_vec(va, wa));
        else n_pass++;
    endtask

    task automatic test_midop_reset();
        vec_t v0 = '{16, -8, 1, -1};
        vec_t w0 = '{12, 4, 1, 1};
        vec_t vb, wb, vc, wc;
        logic [N*W-1:0] got;
        int e, p;
        run_op(v0, w0, got, e, p);
        rand_vec(vb); rand_vec(wb);
        drive(vb, wb);
        VALID_IN = 1'b1;
        tick();
        VALID_IN = 1'b0;
        tick(); tick(); tick();
        #2;
        RSTN = 1'b0;
        #1;
        n_total++;
        if (VALUES_OUT !== '0 || VALID_OUT !== 1'b0 || BUSY_OUT !== 1'b0)
            $display("FAIL midop_reset_async: values=%h valid=%b busy=%b want 0/0/0", VALUES_OUT, VALID_OUT, BUSY_OUT);
        else n_pass++;
        tick();
        RSTN = 1'b1;
        p = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (VALID_OUT) p++;
        end
        n_total++;
        if (p !== 0) $display("FAIL midop_no_publish: pulses=%0d want 0", p);
        else n_pass++;
        rand_vec(vc); rand_vec(wc);
        run_op(vc, wc, got, e, p);
        n_total++;
        if (p !== 1 || e !== 6 || got !== ref_vec(vc, wc))
            $display("FAIL midop_restart: pulses=%0d edge=%0d got %h want 1/6/%h", p, e, got, ref_vec(vc, wc));
        else n_pass++;
    endtask

    task automatic test_random();
        vec_t v, w;
        logic [N*W-1:0] got;
        int e, p;
        for (int t = 0; t < 16; t++) begin
            rand_vec(v); rand_vec(w);
            run_op(v, w, got, e, p);
            n_total++;
            if (p !== 1 || e !== 6 || got !== ref_vec(v, w))
                $display("FAIL random_%0d: pulses=%0d edge=%0d got %h want 1/6/%h", t, p, e, got, ref_vec(v, w));
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        vec_t v [3];
        vec_t w [3];
        logic [N*W-1:0] last, exp_v;
        for (int i = 0; i < 3; i++) begin
            rand_vec(v[i]);
            rand_vec(w[i]);
        end
        last = '0;
        drive(v[0], w[0]);
        VALID_IN = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            tick();
            if (k == 0 || k == 7) drive(v[k / 7 + 1], w[k / 7 + 1]);
            if (k == 14) VALID_IN = 1'b0;
            if (k >= 1) begin
                n_total++;
                if (VALID_OUT !== (k % 7 == 6)) $display("FAIL b2b_valid_e%0d: valid=%b want %b", k, VALID_OUT, (k % 7 == 6));
                else n_pass++;
                if (k % 7 == 6) begin
                    exp_v = ref_vec(v[(k - 6) / 7], w[(k - 6) / 7]);
                    n_total++;
                    if (VALUES_OUT !== exp_v) $display("FAIL b2b_values_e%0d: got %h want %h", k, VALUES_OUT, exp_v);
                    else n_pass++;
                    last = exp_v;
                end else if (k > 6) begin
                    n_total++;
                    if (VALUES_OUT !== last) $display("FAIL b2b_stable_e%0d: got %h want %h", k, VALUES_OUT, last);
                    else n_pass++;
                end
            end
        end
        tick();
        n_total++;
        if (BUSY_OUT !== 1'b0) $display("FAIL b2b_idle: busy=%b want 0", BUSY_OUT);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_busy_ignore();
        test_snapshot();
        test_midop_reset();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fixed_point_vec_mul.md
Name: fixed_point_vec_mul

Overview:
- Element-wise fixed-point multiplier. Produces the packed NUM_OUTPUTS-wide vector that the accumulator stage consumes as its VALUES_IN (this block is the writer; the accumulator is the reader).
- Multiplies each input activation by its weight through one shared, time-multiplexed multiplier, then publishes all products at once with a single VALID_OUT pulse.
- Sits between the weight/activation registers and the neuron accumulator.

Parameters:
- WIDTH, 8, width of every operand and result (two's complement).
- FRAC_BITS, 3, fractional bits; must satisfy 0 < FRAC_BITS < WIDTH.
- NUM_OUTPUTS, 16, number of element pairs per vector; must be >= 2.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RSTN  input  1  reset, asynchronous, active-low.
- VALUES_IN  input  NUM_OUTPUTS*WIDTH  packed signed activations; element i occupies bits [i*WIDTH +: WIDTH].
- WEIGHTS_IN  input  NUM_OUTPUTS*WIDTH  packed signed weights, same packing.
- VALID_IN  input  1  start request; sampled only in IDLE.
- BUSY_OUT  output  1  high in every state except IDLE.
- VALUES_OUT  output  NUM_OUTPUTS*WIDTH  packed signed products, same packing.
- VALID_OUT  output  1  one-cycle pulse when VALUES_OUT is updated.

Behaviour:
- Reset (RSTN low, asynchronous):
  - State goes to IDLE; counters and working register cleared.
  - VALUES_OUT=0, VALID_OUT=0, BUSY_OUT=0.
  - A reset during an operation aborts it; no partial result is ever published.
- States:
  - IDLE: on VALID_IN=1, snapshot VALUES_IN and WEIGHTS_IN into internal registers, set issue_cnt=0 and wr_cnt=0, go to ISSUE. Input ports may change freely after the sampling edge.
  - ISSUE: each cycle, load operand pair issue_cnt into the multiplier with enable=1, then increment issue_cnt. After issuing index NUM_OUTPUTS-1, go to DRAIN.
  - DRAIN: wait for the last multiplier result.
- Result collection (any state):
  - Each multiplier valid writes its product into working-register slot wr_cnt, then increments wr_cnt.
  - When the valid for wr_cnt==NUM_OUTPUTS-1 arrives, on that same edge: copy the full working register (including this last product) into VALUES_OUT, pulse VALID_OUT, and go to IDLE.
- Latency:
  - Edge 0 samples VALID_IN.
  - Element i is issued at edge i+1; its product is valid after edge i+2.
  - VALID_OUT is high for exactly the cycle following edge NUM_OUTPUTS+2.
  - Next-start throughput: NUM_OUTPUTS+3 cycles.
- VALUES_OUT holds its previous value during an operation and changes only together with VALID_OUT.
- VALID_IN while BUSY_OUT=1 is ignored; no queueing. VALID_IN held high continuously restarts on the first IDLE cycle.
- VALID_IN is sampled on the same edge that returns the FSM to IDLE? No: that edge belongs to DRAIN, so the earliest restart sample is the following edge.
- Arithmetic:
  - Full product is 2*WIDTH bits, signed.
  - Arithmetic right shift by FRAC_BITS: truncation toward minus infinity, no rounding.
  - Saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Overflow is never flagged.

Decomposition:
- Shared package/header: state encodings (IDLE, ISSUE, DRAIN) and the clog2 function, already shared with the accumulator.
- One sub-module, fixed_point_mul_sat:
  - Registered 1-cycle multiply, shift, saturate.
  - Ports: CLK, RSTN, VALUE_A_IN, VALUE_B_IN, VALID_IN, VALUE_OUT, VALID_OUT.
  - VALID_OUT is VALID_IN delayed by one cycle; reset clears both outputs.

Test Plan (WIDTH=8, FRAC_BITS=3, NUM_OUTPUTS=4):
- Basic: values {16,-8,1,-1}, weights {12,4,1,1}, VALID_IN pulse at edge 0 -> VALID_OUT high only after edge 6; VALUES_OUT={24,-4,0,-1} (3.0, -0.5, floor 0, floor -0.125); BUSY_OUT high after edges 1..5.
- Saturation: values {127,-128,127,-128}, weights {16,16,-128,-128} -> {127,-128,-128,127}.
- Busy ignore: second VALID_IN with different data at edge 3 -> exactly one VALID_OUT pulse, with first-vector results.
- Snapshot: VALUES_IN changed at edge 1 -> output still reflects the values sampled at edge 0.
- Mid-op reset: RSTN low between edges 3 and 4 -> outputs 0 immediately, no VALID_OUT. A new VALID_IN after release gives the correct result with no stale slots.
- Back-to-back: VALID_IN held high -> VALID_OUT pulses every 7 cycles; VALUES_OUT is stable between pulses.
